// File: rtl/scdb_readout.sv
// scdb_readout: frames secondary_buffer waveforms into a 16-bit sync/header/data/trailer stream.
// Define SCDB_READOUT_CRC_EN to insert a CRC-16-CCITT word before the trailer.
module scdb_readout #(
  parameter int          P_HDR_WIDTH  = 113,
  parameter int          P_DATA_WIDTH = 85,
  parameter int          P_RD_LAT     = 2,
  parameter logic [15:0] P_SYNC_WORD  = 16'hEB90
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    buf_hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  buf_hdr_data,
  output logic                    buf_hdr_rdreq,
  input  logic [P_DATA_WIDTH-1:0] buf_data,
  output logic                    buf_rdreq,
  output logic                    buf_rddone,
  output logic [15:0]             dout,
  output logic                    dout_valid,
  output logic                    dout_last,
  input  logic                    dout_ready,
  output logic                    busy,
  output logic [15:0]             pkt_cnt
);
  localparam int HW = ((P_HDR_WIDTH + 15) / 16) * 16;
  localparam int DW = ((P_DATA_WIDTH + 15) / 16) * 16;
  localparam int HN = HW / 16;
  localparam int DN = DW / 16;
  if (P_RD_LAT < 1 || P_RD_LAT > 5) begin : g_bad_lat
    $error("P_RD_LAT must be 1..5");
  end
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_HDR, S_DATA, S_CRC, S_TRAILER} state_t;
`ifdef SCDB_READOUT_CRC_EN
  localparam state_t L_POST_DATA = S_CRC;
`else
  localparam state_t L_POST_DATA = S_TRAILER;
`endif
  state_t          r_state, w_next;
  logic [HW-1:0]   r_hdr;
  logic [DW-1:0]   r_data;
  logic            r_eoe;
  logic [7:0]      r_idx;
  logic [15:0]     r_words;
  logic [15:0]     r_pkt;
  logic            r_rddone;
  logic [15:0]     w_crc_word;
  logic            w_xfer, w_start, w_hdr_end, w_data_end;
  assign w_xfer        = dout_valid && dout_ready;
  // rst_n gate keeps the pop request quiet while the buffer is itself in reset
  assign w_start       = rst_n && r_state == S_IDLE && en && !buf_hdr_empty;
  assign w_hdr_end     = r_idx == 8'(HN - 1);
  assign w_data_end    = r_idx == 8'(DN - 1);
  assign busy          = r_state != S_IDLE;
  assign dout_valid    = busy;
  assign dout_last     = r_state == S_TRAILER;
  assign buf_hdr_rdreq = w_start;
  assign buf_rdreq     = w_xfer && r_state == S_DATA && r_idx == 8'd0 && !r_eoe;
  assign buf_rddone    = r_rddone;
  assign pkt_cnt       = r_pkt;
  assign dout = r_state == S_SYNC    ? P_SYNC_WORD :
                r_state == S_HDR     ? r_hdr[HW-1 -: 16] :
                r_state == S_DATA    ? r_data[DW-1 -: 16] :
                r_state == S_CRC     ? w_crc_word :
                r_state == S_TRAILER ? r_words : 16'h0;
  always_comb begin
    w_next = r_state;
    if (w_start) w_next = S_SYNC;
    else if (w_xfer)
      case (r_state)
        S_SYNC:    w_next = S_HDR;
        S_HDR:     w_next = w_hdr_end ? S_DATA : S_HDR;
        S_DATA:    w_next = w_data_end ? (r_eoe ? L_POST_DATA : S_DATA) : S_DATA;
        S_CRC:     w_next = S_TRAILER;
        default:   w_next = S_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_hdr    <= '0;
      r_data   <= '0;
      r_eoe    <= 1'b0;
      r_idx    <= '0;
      r_words  <= '0;
      r_pkt    <= '0;
      r_rddone <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rddone <= w_xfer && r_state == S_TRAILER;
      if (w_start) begin
        r_hdr   <= HW'(buf_hdr_data);
        r_data  <= DW'(buf_data);
        r_eoe   <= buf_data[P_DATA_WIDTH-1];
        r_idx   <= '0;
        r_words <= '0;
      end else if (w_xfer) begin
        r_idx <= (r_state == S_HDR && !w_hdr_end) || (r_state == S_DATA && !w_data_end) ? r_idx + 8'd1 : 8'd0;
        if (r_state == S_HDR) r_hdr <= {r_hdr[HW-17:0], 16'h0};
        if (r_state == S_DATA) begin
          r_data <= w_data_end ? DW'(buf_data) : {r_data[DW-17:0], 16'h0};
          if (w_data_end) r_eoe <= buf_data[P_DATA_WIDTH-1];
          if (r_idx == 8'd0 && r_words != 16'hFFFF) r_words <= r_words + 16'd1;
        end
        if (r_state == S_TRAILER) r_pkt <= r_pkt + 16'd1;
      end
    end
`ifdef SCDB_READOUT_CRC_EN
  logic [15:0] r_crc;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 15; i >= 0; i--) x = (x[15] ^ d[i]) ? {x[14:0], 1'b0} ^ 16'h1021 : {x[14:0], 1'b0};
    return x;
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_crc <= '0;
    else if (w_start) r_crc <= 16'hFFFF;
    else if (w_xfer && (r_state == S_HDR || r_state == S_DATA)) r_crc <= crc_step(r_crc, dout);
  assign w_crc_word = r_crc;
`else
  assign w_crc_word = 16'h0;
`endif
endmodule

// File: tb/tb_scdb_readout.sv
// tb_scdb_readout: directed bench with a show-ahead secondary_buffer model and expected-stream builder.
module tb_scdb_readout;
  localparam int RL = 2;
  logic          clk = 1'b0;
  logic          rst_n, en, buf_hdr_empty, buf_hdr_rdreq, buf_rdreq, buf_rddone;
  logic [112:0]  buf_hdr_data;
  logic [84:0]   buf_data;
  logic [15:0]   dout, pkt_cnt;
  logic          dout_valid, dout_last, dout_ready, busy;
  scdb_readout dut (
    .clk(clk), .rst_n(rst_n), .en(en), .buf_hdr_empty(buf_hdr_empty), .buf_hdr_data(buf_hdr_data),
    .buf_hdr_rdreq(buf_hdr_rdreq), .buf_data(buf_data), .buf_rdreq(buf_rdreq), .buf_rddone(buf_rddone),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
    .busy(busy), .pkt_cnt(pkt_cnt)
  );
  always #5 clk = ~clk;
  logic [112:0] hdr_mem [8];
  logic [84:0]  dat_mem [16];
  int           wcnt [8];
  int           wbase [8];
  int           nwf, hi, wi, dp;
  logic [7:0]   rq;
  int           n_cmp = 0, n_bad = 0;
  int           n_rd = 0, n_hrd = 0, n_done = 0, n_stall = 0, cyc = 0, t_last = -100;
  bit           stall_mode = 0, stalled = 0, in_pkt = 0;
  logic [15:0]  held;
  logic [16:0]  got [$];
  logic [16:0]  exp_q [$];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, expv);
    end
  endtask
  // secondary_buffer: header shown only once the previous waveform is released
  assign buf_hdr_empty = (hi >= nwf) || (hi != wi);
  assign buf_hdr_data  = hdr_mem[hi % 8];
  assign buf_data      = dat_mem[dp % 16];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi <= 0; wi <= 0; dp <= 0; rq <= '0;
    end else begin
      if (buf_hdr_rdreq) hi <= hi + 1;
      if (buf_rddone) begin
        wi <= wi + 1;
        dp <= dp + 1;
      end else if (rq[RL-1]) dp <= dp + 1;
      rq <= {rq[6:0], buf_rdreq};
    end
  always @(negedge clk) begin
    cyc++;
    if (buf_rdreq) n_rd++;
    if (buf_hdr_rdreq) n_hrd++;
    if (buf_rddone) n_done++;
    if (!rst_n) in_pkt = 0;
    if (stalled) chk("stall_hold", {15'h0, dout_valid, dout}, {15'h0, 1'b1, held});
    stalled = dout_valid && !dout_ready;
    held = dout;
    if (stalled) n_stall++;
    if (dout_valid && dout_ready) begin
      got.push_back({dout_last, dout});
      if (!in_pkt) begin
        chk("sync_gap", 32'(cyc - t_last >= 2), 1);
        in_pkt = 1;
      end
      if (dout_last) begin
        t_last = cyc;
        in_pkt = 0;
      end
    end
  end
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] d);
    logic fb;
    for (int i = 0; i < 16; i++) begin
      fb = c[15] ^ d[15-i];
      c = c << 1;
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction
  task automatic add_wave(input int w, input int n, input int base);
    hdr_mem[w] = {1'b1, 8'(w), 104'h03_0405_0607_0809_0A0B_0C0D_0E0F};
    wcnt[w] = n;
    wbase[w] = base;
    for (int i = 0; i < n; i++) dat_mem[base+i] = {i == n - 1, 4'(i + 5), 16'(w), 64'h0123_4567_89AB_CDEF};
  endtask
  task automatic build_exp(input int w);
    logic [127:0] hz;
    logic [95:0]  dz;
    logic [15:0]  crc;
    crc = 16'hFFFF;
    hz = 128'(hdr_mem[w]);
    exp_q.push_back({1'b0, 16'hEB90});
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b0, hz[127-16*i -: 16]});
      crc = crc_ref(crc, hz[127-16*i -: 16]);
    end
    for (int j = 0; j < wcnt[w]; j++) begin
      dz = 96'(dat_mem[wbase[w]+j]);
      for (int i = 0; i < 6; i++) begin
        exp_q.push_back({1'b0, dz[95-16*i -: 16]});
        crc = crc_ref(crc, dz[95-16*i -: 16]);
      end
    end
`ifdef SCDB_READOUT_CRC_EN
    exp_q.push_back({1'b0, crc});
`endif
    exp_q.push_back({1'b1, 16'(wcnt[w])});
  endtask
  task automatic cmp_stream();
    int n;
    chk("stream_len", got.size(), exp_q.size());
    n = got.size() < exp_q.size() ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("word%0d", i), 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_pkts(input int n);
    int k;
    k = 0;
    while (pkt_cnt != 16'(n) && k < 600) begin
      @(posedge clk);
      #1;
      if (stall_mode) dout_ready = 1'($urandom_range(0, 1));
      k++;
    end
    dout_ready = 1'b1;
    chk("pkt_cnt", 32'(pkt_cnt), n);
  endtask
  initial begin
    int b_rd, b_hrd, b_done, k;
    for (int i = 0; i < 16; i++) dat_mem[i] = '0;
    add_wave(0, 3, 0);
    add_wave(1, 3, 3);
    add_wave(2, 1, 6);
    add_wave(3, 2, 7);
    add_wave(4, 2, 9);
    add_wave(5, 2, 11);
    rst_n = 1'b0; en = 1'b0; dout_ready = 1'b1; nwf = 0;
    idle(3);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_last", 32'(dout_last), 0);
    chk("rst_pkt", 32'(pkt_cnt), 0);
    chk("rst_strobes", {29'h0, buf_hdr_rdreq, buf_rdreq, buf_rddone}, 0);
    rst_n = 1'b1;
    idle(2);
    // single waveform, 3 data words
    b_rd = n_rd; b_hrd = n_hrd; b_done = n_done;
    nwf = 1; en = 1'b1;
    wait_pkts(1);
    idle(3);
    chk("a_hdr_w0", 32'(got[1]), 32'h0001);
    chk("a_hdr_w1", 32'(got[2]), 32'h0003);
    chk("a_trailer", 32'(got[got.size()-1]), 32'h1_0003);
    chk("a_rdreq", n_rd - b_rd, 2);
    chk("a_hdr_rdreq", n_hrd - b_hrd, 1);
    chk("a_rddone", n_done - b_done, 1);
    build_exp(0);
    cmp_stream();
    // same shape with random backpressure
    b_rd = n_rd; b_done = n_done;
    stall_mode = 1; nwf = 2;
    wait_pkts(2);
    stall_mode = 0;
    idle(3);
    chk("b_stalls_seen", 32'(n_stall > 0), 1);
    chk("b_rdreq", n_rd - b_rd, 2);
    chk("b_rddone", n_done - b_done, 1);
    build_exp(1);
    cmp_stream();
    // two queued waveforms, first is minimum size
    b_done = n_done; b_hrd = n_hrd;
    nwf = 4;
    wait_pkts(4);
    idle(3);
    chk("c_rddone", n_done - b_done, 2);
    chk("c_hdr_rdreq", n_hrd - b_hrd, 2);
    build_exp(2);
    chk("c_min_len", exp_q.size(), 16 + (exp_q.size() - 16 > 0 ? 1 : 0));
    build_exp(3);
    cmp_stream();
    // en low blocks start; a one-cycle en pulse runs a full packet
    en = 1'b0; nwf = 5; b_hrd = n_hrd;
    idle(10);
    chk("d_busy", 32'(busy), 0);
    chk("d_no_pop", n_hrd - b_hrd, 0);
    chk("d_not_empty", 32'(buf_hdr_empty), 0);
    en = 1'b1;
    idle(1);
    en = 1'b0;
    wait_pkts(5);
    idle(3);
    build_exp(4);
    cmp_stream();
    // reset in the middle of the header
    nwf = 6; en = 1'b1;
    k = 0;
    while (got.size() < 2 && k < 50) begin
      idle(1);
      k++;
    end
    chk("e_reach_hdr", 32'(got.size() >= 2), 1);
    b_done = n_done;
    rst_n = 1'b0;
    #1;
    chk("e_valid", 32'(dout_valid), 0);
    chk("e_last", 32'(dout_last), 0);
    chk("e_dout", 32'(dout), 0);
    chk("e_busy", 32'(busy), 0);
    chk("e_pkt", 32'(pkt_cnt), 0);
    nwf = 0;
    idle(2);
    rst_n = 1'b1;
    b_hrd = n_hrd;
    idle(10);
    chk("e_stay_idle", 32'(busy), 0);
    chk("e_no_pop", n_hrd - b_hrd, 0);
    chk("e_no_rddone", n_done - b_done, 0);
    got.delete();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/scdb_readout.md
# scdb_readout

Readout stage directly downstream of `secondary_buffer`. It pops one waveform header and its data words from the secondary buffer, then serializes them into a framed 16-bit word stream with valid/ready flow control for the transmit/DPRAM path. When the waveform's last word has been emitted, it releases the waveform back to the buffer with `buf_rddone`.

## Interface

Parameters:
- `P_HDR_WIDTH`, 113: header width; emitted as `ceil(P_HDR_WIDTH/16)` = 8 words.
- `P_DATA_WIDTH`, 85: data word width.
  - Bit `P_DATA_WIDTH-1` is the end-of-waveform (EOE) flag.
  - Each data word is emitted as 6 words.
- `P_RD_LAT`, 2: cycles from `buf_rdreq` until the next `buf_data` is valid. Legal range 1..5.
- `P_SYNC_WORD`, 16'hEB90: first word of every packet.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: allows a new packet to start. It is sampled only in IDLE.
- `buf_hdr_empty` in 1: secondary buffer has no complete waveform.
- `buf_hdr_data` in `P_HDR_WIDTH`: show-ahead header, valid while `!buf_hdr_empty`.
- `buf_hdr_rdreq` out 1: one-cycle pop of the header.
- `buf_data` in `P_DATA_WIDTH`: show-ahead data word. The first word of the current waveform is valid while `!buf_hdr_empty`.
- `buf_rdreq` out 1: one-cycle advance to the next data word.
- `buf_rddone` out 1: one-cycle pulse; waveform fully consumed.
- `dout` out 16: stream word.
- `dout_valid` out 1: `dout` is valid.
- `dout_last` out 1: marks the final word of a packet.
- `dout_ready` in 1: downstream accepts the word.
- `busy` out 1: high in every state except IDLE.
- `pkt_cnt` out 16: packets completed. Wraps at 2^16.

## Operation

- Packet format:
  - Sync word.
  - 8 header words, MSW first; header zero-extended to 128 bits.
  - N×6 data words, per data word MSW first; zero-extended to 96 bits.
  - Optional CRC word (see Configuration).
  - Trailer = N, saturating at 16'hFFFF.
- Word transfer: occurs on a cycle with `dout_valid && dout_ready`.
  - `dout`, `dout_valid` and `dout_last` hold stable until the word is accepted.
- FSM states:
  - IDLE: on `en && !buf_hdr_empty`:
    - latch `buf_hdr_data` into the header shift register;
    - latch `buf_data` into the data shift register;
    - pulse `buf_hdr_rdreq`;
    - clear the word counter;
    - go to SYNC.
  - SYNC: present `P_SYNC_WORD`; on transfer go to HDR.
  - HDR: 8 transfers, shifting by 16 each; then go to DATA.
  - DATA: 6 transfers of the latched data word.
    - On the first transfer, increment the word counter (saturating) and, if EOE=0, pulse `buf_rdreq`.
    - After the 6th transfer:
      - EOE=1: go to CRC, or to TRAILER when the CRC feature is compiled out.
      - EOE=0: latch `buf_data` and repeat DATA.
  - CRC: one transfer; go to TRAILER.
  - TRAILER: present the word count with `dout_last`=1. On transfer:
    - pulse `buf_rddone`;
    - increment `pkt_cnt`;
    - go to IDLE.
- Because `P_RD_LAT` ≤ 5, the next `buf_data` is already valid when it is latched; DATA needs no wait state.
- `en` falling mid-packet has no effect; the current packet completes.

## Timing

- Reset (async assert, sync release): state=IDLE; all shift registers, counters, `pkt_cnt` and every output = 0.
- Latency:
  - `buf_hdr_rdreq` asserts in the cycle IDLE sees the start condition.
  - Sync word is presented with `dout_valid` on the next cycle.
- Minimum packet with `dout_ready`=1 throughout: 1 + 8 + 6 + 1 = 16 transfer cycles (17 with CRC).
- `buf_rddone` asserts in the cycle after the trailer transfer, concurrent with IDLE.
- Back-to-back packets: IDLE lasts ≥1 cycle, so the next sync word appears ≥2 cycles after the previous trailer transfer.
- `buf_rdreq` asserts at most once per 6 transfers and is never asserted after an EOE word.
- Reset mid-packet: the stream aborts with no `dout_last` and no `buf_rddone`. `secondary_buffer` shares this reset, so the abandoned waveform is discarded there.

## Configuration

- `SCDB_READOUT_CRC_EN` defined:
  - CRC-16-CCITT (poly 0x1021, init 16'hFFFF, MSB-first) computed over every transferred word from the first header word through the last data word.
  - The CRC is emitted as its own word immediately before the trailer.
  - The CRC register re-initializes on entry to SYNC.
- Not defined: no CRC logic; the packet goes from the last data word straight to the trailer.

## Test plan

- Single waveform, 3 data words (EOE on the 3rd), `dout_ready`=1:
  - 16'hEB90, then 8 header words, then 18 data words, then trailer 16'h0003 with `dout_last`;
  - exactly 2 `buf_rdreq` pulses, 1 `buf_hdr_rdreq` pulse and 1 `buf_rddone` pulse;
  - `pkt_cnt`=1.
- Same waveform with `dout_ready` toggled 1-0-0-1 pseudo-randomly: identical word sequence; `dout` held stable across every stall.
- Two waveforms queued, `dout_ready`=1: two complete packets, ≥1 IDLE cycle between them, `pkt_cnt`=2; second header matches the second pop.
- `en`=0 with `buf_hdr_empty`=0: no pops, `busy`=0. Raise `en` for 1 cycle: a full packet is emitted even after `en` drops.
- `rst_n` asserted during HDR: outputs go to 0 immediately, with no `buf_rddone`. After release with `buf_hdr_empty`=1, the block stays IDLE.
- With `SCDB_READOUT_CRC_EN`: the CRC word matches a reference CRC over header plus data, and the trailer follows it. Without the macro, the trailer immediately follows the last data word.
